// File: rtl/sle_bank_ctrl.sv
// Sequences a bank of SLE register cells: round-robin write-port arbitration between two
// requesters with a burst limit, plus a one-shot sync-load init of a fixed pattern.
module sle_bank_ctrl #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      INIT_VAL  = '0,
    parameter int unsigned           MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             aln,
    input  logic             init_req,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             cell_en,
    output logic             cell_sln,
    output logic [WIDTH-1:0] cell_sd,
    output logic [WIDTH-1:0] cell_d,
    output logic             busy,
    output logic             init_done
);

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    typedef enum logic [2:0] {StIdle, StInit, StDone, StGntA, StGntB} state_e;

    state_e     state_q;
    logic       last_b_q;      // last requester served: 1 = B, 0 = A
    logic       init_pend_q;
    logic [7:0] bcnt_q;

    logic             own_req;
    logic             oth_req;
    logic [WIDTH-1:0] own_wdata;
    logic [7:0]       bcnt_inc;
    logic             yield;

    always_comb begin
        own_req   = (state_q == StGntA) ? req_a : req_b;
        oth_req   = (state_q == StGntA) ? req_b : req_a;
        own_wdata = (state_q == StGntA) ? wdata_a : wdata_b;
        bcnt_inc  = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;
        // Once past the limit a late competitor still forces a yield on the next write.
        yield     = (bcnt_inc >= MaxBurst) && (oth_req || init_pend_q);
    end

    always_ff @(posedge clk or negedge aln) begin
        if (!aln) begin
            state_q     <= StIdle;
            last_b_q    <= 1'b1;
            init_pend_q <= 1'b0;
            bcnt_q      <= 8'd0;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            cell_en     <= 1'b0;
            cell_sln    <= 1'b1;
            cell_sd     <= INIT_VAL;
            cell_d      <= '0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            cell_en   <= 1'b0;
            cell_sln  <= 1'b1;
            init_done <= 1'b0;
            if (init_req) begin
                init_pend_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (init_pend_q || init_req) begin
                        state_q     <= StInit;
                        init_pend_q <= 1'b0;
                        cell_en     <= 1'b1;
                        cell_sln    <= 1'b0;
                        cell_sd     <= INIT_VAL;
                        busy        <= 1'b1;
                    end else if (req_a && (!req_b || last_b_q)) begin
                        state_q <= StGntA;
                        gnt_a   <= 1'b1;
                        bcnt_q  <= 8'd0;
                        busy    <= 1'b1;
                    end else if (req_b) begin
                        state_q <= StGntB;
                        gnt_b   <= 1'b1;
                        bcnt_q  <= 8'd0;
                        busy    <= 1'b1;
                    end
                end
                StInit: begin
                    state_q   <= StDone;
                    init_done <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                StGntA, StGntB: begin
                    if (own_req) begin
                        cell_en <= 1'b1;
                        cell_d  <= own_wdata;
                        bcnt_q  <= bcnt_inc;
                    end
                    if (!own_req || yield) begin
                        state_q  <= StIdle;
                        gnt_a    <= 1'b0;
                        gnt_b    <= 1'b0;
                        busy     <= 1'b0;
                        last_b_q <= (state_q == StGntB);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_a   <= 1'b0;
                    gnt_b   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sle_bank_ctrl.sv
// Scoreboard bench for sle_bank_ctrl: per-cycle expected output vectors are queued as stimulus
// is driven and compared after the following clock edge.
module tb_sle_bank_ctrl;

    localparam int unsigned      W    = 8;
    localparam logic [W-1:0]     IVAL = 8'hA5;

    logic         clk = 1'b0;
    logic         aln;
    logic         init_req;
    logic         req_a;
    logic         req_b;
    logic [W-1:0] wdata_a;
    logic [W-1:0] wdata_b;
    logic         gnt_a;
    logic         gnt_b;
    logic         cell_en;
    logic         cell_sln;
    logic [W-1:0] cell_sd;
    logic [W-1:0] cell_d;
    logic         busy;
    logic         init_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_sd;
    logic [W-1:0] exp_d;

    typedef struct {
        string       tag;
        logic [21:0] vec;
    } exp_t;

    exp_t sb[$];

    sle_bank_ctrl #(
        .WIDTH     (W),
        .INIT_VAL  (IVAL),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .aln       (aln),
        .init_req  (init_req),
        .req_a     (req_a),
        .req_b     (req_b),
        .wdata_a   (wdata_a),
        .wdata_b   (wdata_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .cell_en   (cell_en),
        .cell_sln  (cell_sln),
        .cell_sd   (cell_sd),
        .cell_d    (cell_d),
        .busy      (busy),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] dut_vec();
        return {gnt_a, gnt_b, cell_en, cell_sln, busy, init_done, cell_sd, cell_d};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Queue the expected outputs after the next edge, clock, then compare.
    task automatic step(input string tag, input logic ga, input logic gb, input logic en,
                        input logic sln, input logic bsy, input logic dn);
        exp_t e;
        exp_t o;
        e.tag = tag;
        e.vec = {ga, gb, en, sln, bsy, dn, exp_sd, exp_d};
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check_eq(o.tag, {10'd0, dut_vec()}, {10'd0, o.vec});
    endtask

    always @(negedge clk) begin
        check_eq("excl", {31'd0, gnt_a & gnt_b}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        aln      = 1'b0;
        init_req = 1'b0;
        req_a    = 1'b0;
        req_b    = 1'b0;
        wdata_a  = '0;
        wdata_b  = '0;
        exp_sd   = IVAL;
        exp_d    = '0;
        #12;
        check_eq("reset", {10'd0, dut_vec()}, {10'd0, 6'b000100, IVAL, 8'h00});
        aln = 1'b1;

        // Init sequence
        step("idle0", 0, 0, 0, 1, 0, 0);
        init_req = 1'b1;
        step("init", 0, 0, 1, 0, 1, 0);
        init_req = 1'b0;
        step("done", 0, 0, 0, 1, 1, 1);
        step("idle1", 0, 0, 0, 1, 0, 0);

        // Both requesting: A first (last = B after reset), 4 writes, bubble, B, bubble, A
        req_a = 1'b1;
        req_b = 1'b1;
        step("rr_gnt_a", 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            wdata_a = 8'hA0 + 8'(i);
            exp_d   = wdata_a;
            if (i < 3) step("rr_wr_a", 1, 0, 1, 1, 1, 0);
            else       step("rr_yield_a", 0, 0, 1, 1, 0, 0);
        end
        step("rr_gnt_b", 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            wdata_b = 8'hB0 + 8'(i);
            exp_d   = wdata_b;
            if (i < 3) step("rr_wr_b", 0, 1, 1, 1, 1, 0);
            else       step("rr_yield_b", 0, 0, 1, 1, 0, 0);
        end
        step("rr_gnt_a2", 1, 0, 0, 1, 1, 0);
        req_a = 1'b0;
        req_b = 1'b0;
        step("rr_rel", 0, 0, 0, 1, 0, 0);

        // B alone for 10 writes: no yield past the burst limit
        req_b = 1'b1;
        step("solo_gnt_b", 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            wdata_b = 8'h50 + 8'(i);
            exp_d   = wdata_b;
            step("solo_wr_b", 0, 1, 1, 1, 1, 0);
        end
        req_b = 1'b0;
        step("solo_rel_b", 0, 0, 0, 1, 0, 0);

        // A alone: 11, 22, 33 then drop
        req_a   = 1'b1;
        wdata_a = 8'h11;
        step("a_gnt", 1, 0, 0, 1, 1, 0);
        exp_d = 8'h11;
        step("a_wr11", 1, 0, 1, 1, 1, 0);
        wdata_a = 8'h22;
        exp_d   = 8'h22;
        step("a_wr22", 1, 0, 1, 1, 1, 0);
        wdata_a = 8'h33;
        exp_d   = 8'h33;
        step("a_wr33", 1, 0, 1, 1, 1, 0);
        req_a = 1'b0;
        step("a_rel", 0, 0, 0, 1, 0, 0);
        step("a_idle", 0, 0, 0, 1, 0, 0);

        // Init pulsed during an A burst: yield at limit, one IDLE, INIT, DONE, then A again
        req_a = 1'b1;
        step("ia_gnt", 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            wdata_a  = 8'hC0 + 8'(i);
            exp_d    = wdata_a;
            init_req = (i == 0);
            if (i < 3) step("ia_wr", 1, 0, 1, 1, 1, 0);
            else       step("ia_yield", 0, 0, 1, 1, 0, 0);
        end
        init_req = 1'b0;
        step("ia_init", 0, 0, 1, 0, 1, 0);
        step("ia_done", 0, 0, 0, 1, 1, 1);
        step("ia_idle", 0, 0, 0, 1, 0, 0);
        step("ia_regnt", 1, 0, 0, 1, 1, 0);
        req_a = 1'b0;
        step("ia_rel", 0, 0, 0, 1, 0, 0);

        // Async reset mid B burst, with an init pending
        req_b = 1'b1;
        step("rb_gnt", 0, 1, 0, 1, 1, 0);
        wdata_b  = 8'hD0;
        exp_d    = 8'hD0;
        init_req = 1'b1;
        step("rb_wr0", 0, 1, 1, 1, 1, 0);
        init_req = 1'b0;
        wdata_b  = 8'hD1;
        exp_d    = 8'hD1;
        step("rb_wr1", 0, 1, 1, 1, 1, 0);
        #2;
        aln = 1'b0;
        #1;
        check_eq("rb_async", {10'd0, dut_vec()}, {10'd0, 6'b000100, IVAL, 8'h00});
        exp_d = '0;
        req_a = 1'b1;
        #2;
        aln = 1'b1;
        step("rb_post_a", 1, 0, 0, 1, 1, 0);
        req_a = 1'b0;
        step("rb_rel_a", 0, 0, 0, 1, 0, 0);
        step("rb_gnt_b", 0, 1, 0, 1, 1, 0);
        req_b = 1'b0;
        step("rb_rel_b", 0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
